// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: one outstanding operand read with write-queue forwarding,
// and an in-order writeback queue that drains one entry per cycle into the file.
module regfile_access_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int WQ_DEPTH = 4,
    parameter int R0_ZERO  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_rs,
    input  logic [ADDR_W-1:0]         req_rt,
    output logic                      op_valid,
    input  logic                      op_ready,
    output logic [DATA_W-1:0]         op_a,
    output logic [DATA_W-1:0]         op_b,
    input  logic                      wb_valid,
    output logic                      wb_ready,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
    input  logic                      wq_stall,
    output logic [$clog2(WQ_DEPTH):0] wq_count,
    output logic [ADDR_W-1:0]         AA,
    output logic [ADDR_W-1:0]         BA,
    input  logic [DATA_W-1:0]         Aout,
    input  logic [DATA_W-1:0]         Bout,
    output logic [ADDR_W-1:0]         DA,
    output logic [DATA_W-1:0]         D,
    output logic                      RW
);
    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    state_t              state_reg, state_next;
    logic                accept, capture, op_done;
    logic [ADDR_W-1:0]   aa_reg, ba_reg;
    logic [DATA_W-1:0]   op_a_reg, op_b_reg;
    logic                op_valid_reg;

    logic [ADDR_W-1:0]   addr_mem [WQ_DEPTH];
    logic [DATA_W-1:0]   data_mem [WQ_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                push, pop;

    logic [PTR_W-1:0]    slot_age [WQ_DEPTH];
    logic [WQ_DEPTH-1:0] match_a, match_b;
    logic [PTR_W-1:0]    fwd_slot;
    logic [DATA_W-1:0]   fwd_a, fwd_b;

    // Writebacks to r0 still complete their handshake but never occupy a slot.
    assign wb_ready = (count_reg != CNT_W'(WQ_DEPTH));
    assign push     = wb_valid && wb_ready && !((R0_ZERO != 0) && (wb_addr == '0));
    assign RW       = (count_reg != '0) && !wq_stall;
    assign pop      = RW;
    assign DA       = addr_mem[rd_ptr_reg];
    assign D        = data_mem[rd_ptr_reg];
    assign wq_count = count_reg;

    assign AA       = aa_reg;
    assign BA       = ba_reg;
    assign op_a     = op_a_reg;
    assign op_b     = op_b_reg;
    assign op_valid = op_valid_reg;

    // Age 0 is the head; a slot is live when its age is below the occupancy.
    generate
        for (genvar gi = 0; gi < WQ_DEPTH; gi++) begin : g_slot
            assign slot_age[gi] = PTR_W'(gi) - rd_ptr_reg;
            assign match_a[gi]  = ({1'b0, slot_age[gi]} < count_reg) && (addr_mem[gi] == aa_reg);
            assign match_b[gi]  = ({1'b0, slot_age[gi]} < count_reg) && (addr_mem[gi] == ba_reg);
        end
    endgenerate

    // Walk from oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_a    = Aout;
        fwd_b    = Bout;
        fwd_slot = rd_ptr_reg;
        for (int k = 0; k < WQ_DEPTH; k++) begin
            fwd_slot = rd_ptr_reg + PTR_W'(k);
            if (match_a[fwd_slot]) fwd_a = data_mem[fwd_slot];
            if (match_b[fwd_slot]) fwd_b = data_mem[fwd_slot];
        end
        if ((R0_ZERO != 0) && (aa_reg == '0)) fwd_a = '0;
        if ((R0_ZERO != 0) && (ba_reg == '0)) fwd_b = '0;
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        op_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                capture    = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (op_ready) begin
                    op_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            aa_reg       <= '0;
            ba_reg       <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                aa_reg <= req_rs;
                ba_reg <= req_rt;
            end
            if (capture) begin
                op_a_reg     <= fwd_a;
                op_b_reg     <= fwd_b;
                op_valid_reg <= 1'b1;
            end else if (op_done) begin
                op_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < WQ_DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_mem[wr_ptr_reg] <= wb_addr;
                data_mem[wr_ptr_reg] <= wb_data;
                wr_ptr_reg           <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Randomized bench for regfile_access_ctrl: a register file model on the write port,
// plus an architectural reference (latest accepted value per register, pending-write queue).
module tb_regfile_access_ctrl;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int R0Z   = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, op_valid, op_ready;
    logic [AW-1:0] req_rs, req_rt;
    logic [DW-1:0] op_a, op_b;
    logic          wb_valid, wb_ready, wq_stall;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [2:0]    wq_count;
    logic [AW-1:0] AA, BA, DA;
    logic [DW-1:0] Aout, Bout, D;
    logic          RW;

    always #5 clk = ~clk;

    regfile_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WQ_DEPTH(DEPTH), .R0_ZERO(R0Z)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs), .req_rt(req_rt),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .wq_stall(wq_stall), .wq_count(wq_count),
        .AA(AA), .BA(BA), .Aout(Aout), .Bout(Bout), .DA(DA), .D(D), .RW(RW)
    );

    // Register file on the far side of the port set; preloadable while in reset.
    logic [DW-1:0] rf [16];
    logic          rf_load;
    logic [AW-1:0] rf_load_addr;
    logic [DW-1:0] rf_load_data;

    always_ff @(posedge clk) begin
        if (rf_load) rf[rf_load_addr] <= rf_load_data;
        else if (RW) rf[DA] <= D;
    end
    assign Aout = rf[AA];
    assign Bout = rf[BA];

    // Reference model
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wq_t;

    wq_t           mq [$];
    logic [DW-1:0] arch [16];
    int            ph;      // 0 idle, 1 read pending capture, 2 operands presented
    logic [AW-1:0] m_rs, m_rt;
    logic [DW-1:0] exp_a, exp_b;

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] r);
        if (R0Z != 0 && r == '0) return '0;
        return arch[r];
    endfunction

    task automatic step(input logic rv, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic orr, input logic wv, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic st);
        int  sz;
        wq_t e;
        req_valid = rv; req_rs = rs; req_rt = rt; op_ready = orr;
        wb_valid = wv; wb_addr = wa; wb_data = wd; wq_stall = st;
        #1;
        sz = mq.size();
        chk_eq("req_ready", req_ready, ph == 0);
        chk_eq("wb_ready", wb_ready, sz != DEPTH);
        chk_eq("wq_count", wq_count, 32'(sz));
        chk_eq("RW", RW, (sz != 0) && !st);
        if (sz != 0) begin
            chk_eq("DA", DA, mq[0].addr);
            chk_eq("D", D, mq[0].data);
        end
        chk_eq("op_valid", op_valid, ph == 2);
        if (ph == 1) begin
            chk_eq("AA", AA, m_rs);
            chk_eq("BA", BA, m_rt);
        end
        if (ph == 2) begin
            chk_eq("op_a", op_a, exp_a);
            chk_eq("op_b", op_b, exp_b);
        end
        @(posedge clk);
        if (ph == 0) begin
            if (rv) begin
                ph = 1; m_rs = rs; m_rt = rt;
            end
        end else if (ph == 1) begin
            exp_a = ref_rd(m_rs);
            exp_b = ref_rd(m_rt);
            ph    = 2;
        end else if (orr) begin
            ph = 0;
            $display("read rs=%0d rt=%0d a=%h b=%h t=%0t", m_rs, m_rt, op_a, op_b, $time);
        end
        if (sz != 0 && !st) void'(mq.pop_front());
        if (wv && sz != DEPTH && !(R0Z != 0 && wa == '0)) begin
            e.addr = wa; e.data = wd;
            mq.push_back(e);
            arch[wa] = wd;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, st);
    endtask

    task automatic chk_reset_state(input string tag);
        chk_eq({tag, "_RW"}, RW, 0);
        chk_eq({tag, "_wq_count"}, wq_count, 0);
        chk_eq({tag, "_op_valid"}, op_valid, 0);
        chk_eq({tag, "_req_ready"}, req_ready, 1);
        chk_eq({tag, "_wb_ready"}, wb_ready, 1);
        chk_eq({tag, "_op_a"}, op_a, 0);
        chk_eq({tag, "_op_b"}, op_b, 0);
        chk_eq({tag, "_AA"}, AA, 0);
        chk_eq({tag, "_BA"}, BA, 0);
        chk_eq({tag, "_DA"}, DA, 0);
        chk_eq({tag, "_D"}, D, 0);
    endtask

    task automatic mid_reset();
        req_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b1;
        #2 reset = 1'b0;
        #1 chk_reset_state("midrst");
        mq.delete();
        ph = 0;
        for (int r = 0; r < 16; r++) arch[r] = rf[r];
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; rf_load = 1'b1; ph = 0;
        req_valid = 1'b0; req_rs = '0; req_rt = '0; op_ready = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; wq_stall = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rf_load_addr = 4'(i);
            rf_load_data = (i == 0) ? 16'h1234 : 16'($urandom);
            @(negedge clk);
        end
        rf_load = 1'b0;
        chk_reset_state("rst");
        for (int r = 0; r < 16; r++) arch[r] = rf[r];
        reset = 1'b1;

        // In-order drain of three back-to-back writebacks
        step(0, 0, 0, 1, 1, 4'd1, 16'h0004, 0);
        step(0, 0, 0, 1, 1, 4'd2, 16'h0006, 0);
        step(0, 0, 0, 1, 1, 4'd3, 16'h0008, 0);
        idle(2, 0);

        // Stalled queue: youngest matching entry is forwarded to both operands
        step(0, 0, 0, 1, 1, 4'd5, 16'h1111, 1);
        step(0, 0, 0, 1, 1, 4'd5, 16'h2222, 1);
        step(1, 4'd5, 4'd5, 0, 0, 0, 0, 1);
        idle(3, 1);
        idle(3, 0);

        // Fill to full under stall; fifth request waits for space
        step(0, 0, 0, 1, 1, 4'd6, 16'hA001, 1);
        step(0, 0, 0, 1, 1, 4'd7, 16'hA002, 1);
        step(0, 0, 0, 1, 1, 4'd8, 16'hA003, 1);
        step(0, 0, 0, 1, 1, 4'd9, 16'hA004, 1);
        step(0, 0, 0, 1, 1, 4'd10, 16'hA005, 1);
        step(0, 0, 0, 1, 1, 4'd10, 16'hA005, 0);
        step(0, 0, 0, 1, 1, 4'd10, 16'hA005, 0);
        idle(5, 0);

        // Read served from the file, operands held while the consumer stalls
        step(0, 0, 0, 1, 1, 4'd7, 16'hBEEF, 0);
        idle(2, 0);
        step(1, 4'd7, 4'd2, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 0);

        // r0: write dropped, read forced to zero despite Aout=0x1234
        step(0, 0, 0, 1, 1, 4'd0, 16'hFFFF, 0);
        step(1, 4'd0, 4'd1, 0, 0, 0, 0, 0);
        idle(3, 0);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                 16'($urandom), ($urandom_range(0, 3) == 0));
        idle(8, 0);

        // Asynchronous reset in the middle of a read with three queued writes
        step(0, 0, 0, 1, 1, 4'd8, 16'hC008, 1);
        step(0, 0, 0, 1, 1, 4'd9, 16'hC009, 1);
        step(0, 0, 0, 1, 1, 4'd10, 16'hC00A, 1);
        step(1, 4'd8, 4'd9, 0, 0, 0, 0, 1);
        mid_reset();
        step(1, 4'd8, 4'd9, 0, 0, 0, 0, 0);
        idle(3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
